triangle_scan_ctrl: RTL and testbench
=====================================

# triangle_scan_ctrl

Sequential scan controller around the point-in-triangle edge test. It accepts one triangle and sweeps every integer point of the triangle's bounding box in raster order. Each point is evaluated with a single time-shared edge-function unit, one edge per cycle. Inside points stream out over a valid/ready port, and a done pulse with the final inside count ends the scan.

## Interface
- COORD_W, 10, coordinate width; all coordinates unsigned
- CNT_W, 2*COORD_W+1, width of inside-point counter
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start_valid  in  1  triangle present on xa..yc
- start_ready  out  1  high only in IDLE
- xa, ya, xb, yb, xc, yc  in  COORD_W each  vertices A, B, C; registered on start handshake
- pix_valid  out  1  inside point available
- pix_ready  in  1  consumer accepts point
- pix_x, pix_y  out  COORD_W each  inside point coordinates
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of scan
- count  out  CNT_W  inside points emitted in current/last scan

## Operation
- States: IDLE, BBOX, EVAL0, EVAL1, EVAL2, EMIT, NEXT, DONE.
- IDLE: on start_valid & start_ready, register the six vertices, clear count, and go to BBOX. The vertices are held constant until the next start.
- BBOX: register xmin/xmax/ymin/ymax as min/max over the vertices. Set cur_x=xmin, cur_y=ymin. Go to EVAL0.
- Edge function for edge (P,Q): E = (cur_x-Px)*(Qy-Py) - (cur_y-Py)*(Qx-Px).
  - Each difference is a COORD_W+1-bit signed value from zero-extended operands.
  - Products are 2*COORD_W+2 bits; E is 2*COORD_W+3-bit signed.
  - No truncation is allowed.
- EVAL0, EVAL1, EVAL2 evaluate edges AB, BC, CA respectively on the one shared unit. Each registers two flags: pos (E>0) and neg (E<0).
- Inside is strict: all three pos, or all three neg. Any E==0 is outside. A degenerate triangle therefore emits nothing.
- EVAL2 goes to EMIT if inside, else to NEXT. The decision uses the EVAL2 result combinationally with the stored EVAL0/EVAL1 flags.
- EMIT: pix_valid=1 and pix_x/pix_y=cur_x/cur_y, all held stable until pix_ready. On handshake, count+1 and go to NEXT.
- NEXT:
  - If cur_x==xmax and cur_y==ymax, go to DONE.
  - Else if cur_x==xmax, set cur_x=xmin and cur_y+1.
  - Else cur_x+1.
  - Then go to EVAL0.
- DONE: done=1 for exactly this cycle, then IDLE. count holds until the next accepted start.
- start_valid outside IDLE is ignored, with no queuing.
- A single-point box (xmin==xmax, ymin==ymax) is scanned as one point.

## Timing
- Reset values: start_ready=1 (IDLE), busy=0, pix_valid=0, pix_x=0, pix_y=0, done=0, count=0, state IDLE.
- Reset asserted mid-scan aborts immediately and asynchronously. pix_valid drops, no done is issued, and count=0.
- Start accepted at edge k:
  - BBOX is cycle k+1.
  - The first EVAL0 is cycle k+2.
- Per point:
  - Outside point: 4 cycles (EVAL0, EVAL1, EVAL2, NEXT).
  - Inside point with pix_ready high: 5 cycles.
  - Each cycle pix_ready is low adds one cycle.
- done is high in cycle k+2+4N+M+S, where:
  - N = box points
  - M = inside points
  - S = total stall cycles
- start_ready returns high the cycle after done.
- pix_valid is asserted only in EMIT. It never deasserts without a handshake, except on reset.

## Test plan
- A(0,0) B(4,0) C(0,4), pix_ready=1, start at edge k:
  - pix sequence is (1,1), (2,1), (1,2).
  - done at k+105 with count=3.
- Clockwise A(0,0) B(0,4) C(4,0): same three pixels, same order, count=3.
- Collinear A(1,1) B(2,2) C(3,3):
  - pix_valid never high.
  - done at k+38, count=0.
  - Repeat with A=B=C=(5,5): done at k+6, count=0.
- Scenario 1 with pix_ready held low for 10 cycles at first pix_valid:
  - pix_x/pix_y stay (1,1) throughout.
  - done at k+115, count=3.
- start_valid pulsed with a different triangle during scenario 1: ignored; results identical to scenario 1.
- Reset asserted while in EMIT:
  - pix_valid=0, busy=0, count=0 immediately; no done.
  - After release, a new start of scenario 1 reproduces scenario 1 exactly.

Source files
------------

// File: rtl/triangle_scan_ctrl_if.sv
// rtl/triangle_scan_ctrl_if.sv - start/pixel handshake bundle for the triangle scan controller
interface triangle_scan_ctrl_if #(
  parameter int COORD_W = 10,
  parameter int CNT_W   = 2*COORD_W+1
);
  logic               start_valid;
  logic               start_ready;
  logic [COORD_W-1:0] xa, ya, xb, yb, xc, yc;
  logic               pix_valid;
  logic               pix_ready;
  logic [COORD_W-1:0] pix_x, pix_y;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   count;

  modport master (
    output start_valid, xa, ya, xb, yb, xc, yc, pix_ready,
    input  start_ready, pix_valid, pix_x, pix_y, busy, done, count
  );

  modport slave (
    input  start_valid, xa, ya, xb, yb, xc, yc, pix_ready,
    output start_ready, pix_valid, pix_x, pix_y, busy, done, count
  );
endinterface

// File: rtl/triangle_scan_ctrl.sv
// rtl/triangle_scan_ctrl.sv - raster scan of a triangle bounding box, one edge test per cycle
module triangle_scan_ctrl #(
  parameter int COORD_W = 10,
  parameter int CNT_W   = 2*COORD_W+1
) (
  input  logic                clk,
  input  logic                rst,
  triangle_scan_ctrl_if.slave bus
);
  localparam int EW = 2*COORD_W+3;

  typedef enum logic [2:0] {
    S_IDLE, S_BBOX, S_EVAL0, S_EVAL1, S_EVAL2, S_EMIT, S_NEXT, S_DONE
  } state_t;

  state_t             r_state;
  logic [COORD_W-1:0] r_xa, r_ya, r_xb, r_yb, r_xc, r_yc;
  logic [COORD_W-1:0] r_xmin, r_xmax, r_ymin, r_ymax;
  logic [COORD_W-1:0] r_cur_x, r_cur_y;
  logic               r_pos0, r_neg0, r_pos1, r_neg1;
  logic [CNT_W-1:0]   r_count;
  logic               r_pix_valid, r_done, r_busy, r_start_ready;
  logic [COORD_W-1:0] r_pix_x, r_pix_y;

  logic [COORD_W-1:0]          w_px, w_py, w_qx, w_qy;
  logic [COORD_W-1:0]          w_xmin, w_xmax, w_ymin, w_ymax;
  logic signed [COORD_W:0]     w_dxp, w_dyp, w_dqx, w_dqy;
  logic signed [2*COORD_W+1:0] w_p1, w_p2;
  logic signed [EW-1:0]        w_e;
  logic                        w_pos, w_neg, w_inside;

  // The one shared edge unit: EVAL0 -> AB, EVAL1 -> BC, otherwise CA.
  always_comb begin
    w_px = r_xc; w_py = r_yc; w_qx = r_xa; w_qy = r_ya;
    if (r_state == S_EVAL0) begin
      w_px = r_xa; w_py = r_ya; w_qx = r_xb; w_qy = r_yb;
    end else if (r_state == S_EVAL1) begin
      w_px = r_xb; w_py = r_yb; w_qx = r_xc; w_qy = r_yc;
    end
  end

  always_comb begin
    w_xmin = (r_xa < r_xb) ? r_xa : r_xb;
    w_xmin = (r_xc < w_xmin) ? r_xc : w_xmin;
    w_xmax = (r_xa > r_xb) ? r_xa : r_xb;
    w_xmax = (r_xc > w_xmax) ? r_xc : w_xmax;
    w_ymin = (r_ya < r_yb) ? r_ya : r_yb;
    w_ymin = (r_yc < w_ymin) ? r_yc : w_ymin;
    w_ymax = (r_ya > r_yb) ? r_ya : r_yb;
    w_ymax = (r_yc > w_ymax) ? r_yc : w_ymax;
  end

  assign w_dxp = $signed({1'b0, r_cur_x}) - $signed({1'b0, w_px});
  assign w_dyp = $signed({1'b0, r_cur_y}) - $signed({1'b0, w_py});
  assign w_dqx = $signed({1'b0, w_qx}) - $signed({1'b0, w_px});
  assign w_dqy = $signed({1'b0, w_qy}) - $signed({1'b0, w_py});
  assign w_p1  = $signed({{(COORD_W+1){w_dxp[COORD_W]}}, w_dxp}) *
                 $signed({{(COORD_W+1){w_dqy[COORD_W]}}, w_dqy});
  assign w_p2  = $signed({{(COORD_W+1){w_dyp[COORD_W]}}, w_dyp}) *
                 $signed({{(COORD_W+1){w_dqx[COORD_W]}}, w_dqx});
  assign w_e   = $signed({w_p1[2*COORD_W+1], w_p1}) - $signed({w_p2[2*COORD_W+1], w_p2});
  assign w_neg = w_e[EW-1];
  assign w_pos = !w_e[EW-1] && (w_e != '0);
  assign w_inside = (r_pos0 && r_pos1 && w_pos) || (r_neg0 && r_neg1 && w_neg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_xa <= '0; r_ya <= '0; r_xb <= '0; r_yb <= '0; r_xc <= '0; r_yc <= '0;
      r_xmin <= '0; r_xmax <= '0; r_ymin <= '0; r_ymax <= '0;
      r_cur_x       <= '0;
      r_cur_y       <= '0;
      r_pos0 <= 1'b0; r_neg0 <= 1'b0; r_pos1 <= 1'b0; r_neg1 <= 1'b0;
      r_count       <= '0;
      r_pix_valid   <= 1'b0;
      r_pix_x       <= '0;
      r_pix_y       <= '0;
      r_done        <= 1'b0;
      r_busy        <= 1'b0;
      r_start_ready <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.start_valid) begin
          r_xa <= bus.xa; r_ya <= bus.ya; r_xb <= bus.xb;
          r_yb <= bus.yb; r_xc <= bus.xc; r_yc <= bus.yc;
          r_count       <= '0;
          r_start_ready <= 1'b0;
          r_busy        <= 1'b1;
          r_state       <= S_BBOX;
        end
        S_BBOX: begin
          r_xmin  <= w_xmin; r_xmax <= w_xmax;
          r_ymin  <= w_ymin; r_ymax <= w_ymax;
          r_cur_x <= w_xmin;
          r_cur_y <= w_ymin;
          r_state <= S_EVAL0;
        end
        S_EVAL0: begin
          r_pos0  <= w_pos;
          r_neg0  <= w_neg;
          r_state <= S_EVAL1;
        end
        S_EVAL1: begin
          r_pos1  <= w_pos;
          r_neg1  <= w_neg;
          r_state <= S_EVAL2;
        end
        S_EVAL2: if (w_inside) begin
          r_pix_valid <= 1'b1;
          r_pix_x     <= r_cur_x;
          r_pix_y     <= r_cur_y;
          r_state     <= S_EMIT;
        end else begin
          r_state <= S_NEXT;
        end
        S_EMIT: if (bus.pix_ready) begin
          r_pix_valid <= 1'b0;
          r_count     <= r_count + CNT_W'(1);
          r_state     <= S_NEXT;
        end
        S_NEXT: begin
          if (r_cur_x == r_xmax && r_cur_y == r_ymax) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            if (r_cur_x == r_xmax) begin
              r_cur_x <= r_xmin;
              r_cur_y <= r_cur_y + COORD_W'(1);
            end else begin
              r_cur_x <= r_cur_x + COORD_W'(1);
            end
            r_state <= S_EVAL0;
          end
        end
        S_DONE: begin
          r_busy        <= 1'b0;
          r_start_ready <= 1'b1;
          r_state       <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.start_ready = r_start_ready;
  assign bus.pix_valid   = r_pix_valid;
  assign bus.pix_x       = r_pix_x;
  assign bus.pix_y       = r_pix_y;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.count       = r_count;
endmodule

// File: tb/tb_triangle_scan_ctrl.sv
// tb/tb_triangle_scan_ctrl.sv - directed bench for triangle_scan_ctrl
module tb_triangle_scan_ctrl;
  localparam int COORD_W = 10;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   exp_pix[$];

  always #5 clk = ~clk;

  triangle_scan_ctrl_if #(.COORD_W(COORD_W)) bus ();
  triangle_scan_ctrl #(.COORD_W(COORD_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic set_tri1_pixels();
    exp_pix.delete();
    exp_pix.push_back(1*1024 + 1);
    exp_pix.push_back(2*1024 + 1);
    exp_pix.push_back(1*1024 + 2);
  endtask

  task automatic drive_tri(input int ax, ay, bx, by, cx, cy);
    bus.xa = 10'(ax); bus.ya = 10'(ay);
    bus.xb = 10'(bx); bus.yb = 10'(by);
    bus.xc = 10'(cx); bus.yc = 10'(cy);
  endtask

  // n counts negedges after the accepting edge k, so n equals the cycle offset from k.
  task automatic run_scan(input string tag, input int ax, ay, bx, by, cx, cy,
                          input int stall_n, input bit inject,
                          input int exp_done, input int exp_cnt);
    int n = 0, stalls = 0, npix = 0, done_n = -1, unstable = 0;
    @(negedge clk);
    drive_tri(ax, ay, bx, by, cx, cy);
    bus.start_valid = 1'b1;
    bus.pix_ready   = (stall_n == 0);
    chk({tag, " idle start_ready"}, bus.start_ready, 1);
    while (done_n < 0 && n < 3000) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        bus.start_valid = 1'b0;
        chk({tag, " busy after start"}, bus.busy, 1);
        chk({tag, " start_ready after start"}, bus.start_ready, 0);
      end
      if (inject && n == 20) begin
        bus.start_valid = 1'b1;
        drive_tri(0, 0, 9, 0, 0, 9);
      end
      if (inject && n == 22) bus.start_valid = 1'b0;
      if (bus.pix_valid) begin
        if (stalls < stall_n) begin
          bus.pix_ready = 1'b0;
          stalls++;
          if (int'(bus.pix_x) * 1024 + int'(bus.pix_y) != exp_pix[0]) unstable++;
        end else begin
          bus.pix_ready = 1'b1;
          if (npix < exp_pix.size())
            chk($sformatf("%s pixel %0d (x*1024+y)", tag, npix),
                int'(bus.pix_x) * 1024 + int'(bus.pix_y), exp_pix[npix]);
          npix++;
        end
      end
      if (bus.done) begin
        done_n = n;
        chk({tag, " count at done"}, bus.count, exp_cnt);
      end
    end
    chk({tag, " done cycle offset"}, done_n, exp_done);
    chk({tag, " pixels emitted"}, npix, exp_cnt);
    if (stall_n > 0) begin
      chk({tag, " stall cycles"}, stalls, stall_n);
      chk({tag, " pixel unstable during stall"}, unstable, 0);
    end
    @(negedge clk);
    chk({tag, " done one cycle"}, bus.done, 0);
    chk({tag, " start_ready after done"}, bus.start_ready, 1);
    chk({tag, " count holds"}, bus.count, exp_cnt);
  endtask

  initial begin
    int n, seen;
    rst = 1'b1;
    bus.start_valid = 1'b0;
    bus.pix_ready   = 1'b1;
    drive_tri(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset start_ready", bus.start_ready, 1);
    chk("reset busy", bus.busy, 0);
    chk("reset pix_valid", bus.pix_valid, 0);
    chk("reset pix_x", bus.pix_x, 0);
    chk("reset pix_y", bus.pix_y, 0);
    chk("reset done", bus.done, 0);
    chk("reset count", bus.count, 0);
    rst = 1'b0;

    set_tri1_pixels();
    run_scan("ccw", 0, 0, 4, 0, 0, 4, 0, 1'b0, 105, 3);
    run_scan("cw", 0, 0, 0, 4, 4, 0, 0, 1'b0, 105, 3);
    run_scan("stall", 0, 0, 4, 0, 0, 4, 10, 1'b0, 115, 3);
    run_scan("inject", 0, 0, 4, 0, 0, 4, 0, 1'b1, 105, 3);

    exp_pix.delete();
    run_scan("collinear", 1, 1, 2, 2, 3, 3, 0, 1'b0, 38, 0);
    run_scan("point", 5, 5, 5, 5, 5, 5, 0, 1'b0, 6, 0);

    // Abort while the second pixel of triangle 1 is being offered.
    set_tri1_pixels();
    @(negedge clk);
    drive_tri(0, 0, 4, 0, 0, 4);
    bus.start_valid = 1'b1;
    bus.pix_ready   = 1'b1;
    n = 0;
    seen = 0;
    while (n < 500 && seen < 2) begin
      @(negedge clk);
      n++;
      if (n == 1) bus.start_valid = 1'b0;
      if (bus.pix_valid) seen++;
    end
    chk("abort reached second emit", seen, 2);
    chk("abort count before reset", bus.count, 1);
    rst = 1'b1;
    #1;
    chk("abort pix_valid", bus.pix_valid, 0);
    chk("abort busy", bus.busy, 0);
    chk("abort count", bus.count, 0);
    chk("abort start_ready", bus.start_ready, 1);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    chk("abort no done", seen, 0);
    rst = 1'b0;
    run_scan("after abort", 0, 0, 4, 0, 0, 4, 0, 1'b0, 105, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
